// File: rtl/ring_counter4.sv
// One-hot ring counter: ori seeds 0001, otherwise the ring rotates left one place per clk.
// Latency one clock per step; rst clears count asynchronously; no flow control.
module ring_counter4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ori,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Seed overrides rotation; an all-zero ring stays zero until seeded.
  always_comb begin
    count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    if (ori) begin
      count_d    = '0;
      count_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_ring_counter4.sv
// Bench for ring_counter4: directed scenarios then random seed/reset traffic,
// compared against a position-based model of the circulating bit.
module tb_ring_counter4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ori;
  logic [W-1:0] count;

  int total = 0;
  int bad   = 0;
  int pos   = -1;  // index of the circulating 1, -1 when the ring is empty

  always #5 clk = ~clk;

  ring_counter4 #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ori  (ori),
    .count(count)
  );

  function automatic logic [W-1:0] model_val();
    logic [W-1:0] v;
    v = '0;
    if (pos >= 0) v[pos] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst)           pos = -1;
    else if (ori)      pos = 0;
    else if (pos >= 0) pos = (pos + 1) % W;
    #1;
    chk(tag, 32'(count), 32'(model_val()));
    chk({tag, "_onehot"}, 32'($countones(count) == 1), 32'(pos >= 0));
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    pos = -1;
    chk(tag, 32'(count), 32'(model_val()));
  endtask

  initial begin
    int period;
    rst = 1'b0;
    ori = 1'b1;
    #2;
    async_reset("rst_imm");
    step("rst_hold0");
    step("rst_hold1");

    @(negedge clk);
    rst = 1'b0;
    ori = 1'b1;
    step("seed");
    step("seed_held0");
    step("seed_held1");
    chk("seed_value", 32'(count), 32'h1);

    @(negedge clk);
    ori = 1'b0;
    for (int i = 0; i < 5; i++) step("rotate");
    chk("rotate_end", 32'(count), 32'h2);

    period = 0;
    for (int i = 0; i < 8; i++) begin
      step("period_walk");
      period++;
      if (count == 4'b0010) break;
    end
    chk("period", 32'(period), 32'(W));

    @(negedge clk);
    async_reset("rst_noself");
    @(negedge clk);
    rst = 1'b0;
    ori = 1'b0;
    for (int i = 0; i < 6; i++) step("no_self_start");
    chk("no_self_zero", 32'(count), 32'h0);

    @(negedge clk);
    ori = 1'b1;
    step("seed2");
    @(negedge clk);
    ori = 1'b0;
    step("r2a");
    step("r2b");
    chk("at_0100", 32'(count), 32'h4);
    @(negedge clk);
    async_reset("rst_midring");
    @(negedge clk);
    rst = 1'b0;
    ori = 1'b1;
    step("reseed_after_rst");
    @(negedge clk);
    ori = 1'b0;
    step("resume");
    step("to_0100");
    step("to_1000");
    chk("at_1000", 32'(count), 32'h8);
    @(negedge clk);
    ori = 1'b1;
    step("reseed_mid");
    chk("reseed_not_wrap", 32'(count), 32'h1);
    @(negedge clk);
    ori = 1'b0;
    step("after_reseed");

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 19) == 0) async_reset("rand_rst");
      ori = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
